reg_bank_tristate: RTL and testbench

Parametrised multi-channel bus register bank, successor to the dual 8-bit clocked tristate register parts.
- Each of NCH channels holds a WIDTH-bit staging register that can hold, load, increment or shift.
- A separate output register is updated from staging only on an explicit COMMIT, so a value can be built over several cycles without glitching the bus.
- Outputs are individually tristated onto shared buses.

---
 rtl/reg_bank_tristate.sv | 126 ++++++++++++
 tb/tb_reg_bank_tristate.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_tristate.sv
// ---------------------------------------------------------------------------
// reg_bank_tristate
//   Multi-channel bus register bank. Each channel has a WIDTH-bit staging
//   register (hold / load / increment / shift-left) and a separate output
//   register. The output register takes the staging value only on COMMIT, so
//   a value can be assembled over several cycles while the bus stays steady.
//   Each channel's output register drives its own slice of Q through an
//   active-low tristate enable.
//
// Ports
//   CLK     sole clock, posedge
//   RST     asynchronous active-high reset (clears staging, output, CARRY)
//   D       parallel load data, channel c at [c*WIDTH +: WIDTH]
//   LE      per-channel staging enable
//   MODE    shared staging op: 00 hold, 01 load, 10 increment, 11 shift-left
//   SIN     per-channel serial input for shift-left
//   COMMIT  copy every staging register to its output register
//   N_OE    per-channel active-low output enable (combinational, no state)
//   Q       per-channel output register value, or Z when disabled
//   CARRY   per-channel registered wrap flag from increment
// ---------------------------------------------------------------------------

// One channel: staging register, output register and wrap flag.
//   le/mode/sin/d  staging control and data for this channel
//   commit         shared commit strobe
//   out_q          output register value
//   carry          wrap flag, updated only by increments
module reg_bank_tristate_lane #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             le,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  input  logic             commit,
  output logic [WIDTH-1:0] out_q,
  output logic             carry
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_INC  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] stage_q, stage_d;
  logic             carry_d;
  mode_e            op;

  assign op = mode_e'(mode);

  always_comb begin
    stage_d = stage_q;
    carry_d = carry;
    if (le) begin
      unique case (op)
        MODE_HOLD: stage_d = stage_q;
        MODE_LOAD: stage_d = d;
        MODE_INC: begin
          stage_d = stage_q + 1'b1;
          carry_d = &stage_q;
        end
        MODE_SHL:  stage_d = {stage_q[WIDTH-2:0], sin};
        default:   stage_d = stage_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_q <= '0;
      carry   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      carry   <= carry_d;
    end
  end

  // Commit samples the pre-edge staging value: an update on the same edge
  // only becomes visible after a later commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         out_q <= '0;
    else if (commit) out_q <= stage_q;
  end

endmodule

module reg_bank_tristate #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*WIDTH-1:0] D,
  input  logic [NCH-1:0]       LE,
  input  logic [1:0]           MODE,
  input  logic [NCH-1:0]       SIN,
  input  logic                 COMMIT,
  input  logic [NCH-1:0]       N_OE,
  output logic [NCH*WIDTH-1:0] Q,
  output logic [NCH-1:0]       CARRY
);

  logic [NCH-1:0][WIDTH-1:0] out_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    reg_bank_tristate_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .le     (LE[c]),
      .mode   (MODE),
      .sin    (SIN[c]),
      .d      (D[c*WIDTH +: WIDTH]),
      .commit (COMMIT),
      .out_q  (out_q[c]),
      .carry  (CARRY[c])
    );

    // Output enable is a pure combinational gate onto the shared bus.
    assign Q[c*WIDTH +: WIDTH] = N_OE[c] ? {WIDTH{1'bz}} : out_q[c];
  end

endmodule

// File: tb/tb_reg_bank_tristate.sv
module tb_reg_bank_tristate;

  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int BW  = NCH*W;

  logic           CLK = 1'b0;
  logic           RST;
  logic [BW-1:0]  D;
  logic [NCH-1:0] LE;
  logic [1:0]     MODE;
  logic [NCH-1:0] SIN;
  logic           COMMIT;
  logic [NCH-1:0] N_OE;
  wire  [BW-1:0]  Q;
  wire  [NCH-1:0] CARRY;

  reg_bank_tristate #(.WIDTH(W), .NCH(NCH)) dut (
    .CLK(CLK), .RST(RST), .D(D), .LE(LE), .MODE(MODE), .SIN(SIN),
    .COMMIT(COMMIT), .N_OE(N_OE), .Q(Q), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] m_stage [NCH];
  logic [W-1:0] m_out   [NCH];
  logic         m_carry [NCH];

  typedef struct {
    string          tag;
    logic [BW-1:0]  q;
    logic [BW-1:0]  mask;
    logic [NCH-1:0] carry;
  } sb_t;

  sb_t sb[$];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_stage[c] = '0;
      m_out[c]   = '0;
      m_carry[c] = 1'b0;
    end
  endfunction

  // Drive one cycle's inputs at the negedge and queue the state expected
  // after the following posedge.
  task automatic cyc(input string tag, input logic [NCH-1:0] le, input logic [1:0] mode,
                     input logic [BW-1:0] d, input logic [NCH-1:0] sin,
                     input logic commit, input logic [NCH-1:0] noe);
    sb_t e;
    @(negedge CLK);
    LE = le; MODE = mode; D = d; SIN = sin; COMMIT = commit; N_OE = noe;
    if (commit)
      for (int c = 0; c < NCH; c++) m_out[c] = m_stage[c];
    for (int c = 0; c < NCH; c++) begin
      if (le[c]) begin
        case (mode)
          2'b01: m_stage[c] = d[c*W +: W];
          2'b10: begin
            m_carry[c] = (m_stage[c] == {W{1'b1}});
            m_stage[c] = m_stage[c] + 1'b1;
          end
          2'b11: m_stage[c] = {m_stage[c][W-2:0], sin[c]};
          default: ;
        endcase
      end
    end
    e.tag = tag;
    for (int c = 0; c < NCH; c++) begin
      e.q[c*W +: W]    = m_out[c];
      e.mask[c*W +: W] = noe[c] ? '0 : {W{1'b1}};
      e.carry[c]       = m_carry[c];
    end
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic commit, input logic [NCH-1:0] noe);
    cyc(tag, '0, 2'b00, '0, '0, commit, noe);
  endtask

  // Land just after the edge and after the monitor has popped.
  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      chk({e.tag, "_q"},     32'(Q & e.mask), 32'(e.q & e.mask));
      chk({e.tag, "_carry"}, 32'(CARRY),      32'(e.carry));
    end
  end

  initial begin
    RST = 1'b1; D = '0; LE = '0; MODE = 2'b00; SIN = '0; COMMIT = 1'b0; N_OE = '0;
    model_reset();
    #12;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_carry", 32'(CARRY), 32'h0);
    RST = 1'b0;
    idle("post_rst0", 1'b0, 2'b00);
    idle("post_rst1", 1'b1, 2'b00);

    // Load, then commit: Q changes only after the second edge.
    cyc("load", 2'b11, 2'b01, 16'hA55A, '0, 1'b0, 2'b00);
    idle("commit1", 1'b1, 2'b00);
    settle();
    chk("lit_a55a", 32'(Q), 32'h0000A55A);

    // Commit on the load edge publishes the old staging value.
    cyc("load_commit", 2'b11, 2'b01, 16'h1234, '0, 1'b1, 2'b00);
    settle();
    chk("lit_keep", 32'(Q), 32'h0000A55A);
    idle("commit2", 1'b1, 2'b00);

    // Increment wrap on ch0; ch1 disabled throughout.
    cyc("ld_fe", 2'b01, 2'b01, 16'hFFFE, '0, 1'b0, 2'b00);
    cyc("inc1", 2'b01, 2'b10, '0, '0, 1'b0, 2'b00);
    idle("c_ff", 1'b1, 2'b00);
    settle();
    chk("lit_ff", 32'(Q), 32'h000012FF);
    cyc("inc2", 2'b01, 2'b10, '0, '0, 1'b0, 2'b00);
    idle("c_00", 1'b1, 2'b00);
    settle();
    chk("lit_wrap", 32'(Q), 32'h00001200);
    chk("lit_carry1", 32'(CARRY), 32'h1);
    cyc("inc3", 2'b01, 2'b10, '0, '0, 1'b1, 2'b00);
    idle("c_01", 1'b1, 2'b00);
    settle();
    chk("lit_01", 32'(Q), 32'h00001201);
    chk("lit_carry0", 32'(CARRY), 32'h0);

    // Shift ch1: 81 -> 03 -> 06 -> 0D
    cyc("ld_81", 2'b10, 2'b01, 16'h8100, '0, 1'b0, 2'b00);
    cyc("sh1", 2'b10, 2'b11, '0, 2'b10, 1'b0, 2'b00);
    cyc("sh0", 2'b10, 2'b11, '0, 2'b00, 1'b0, 2'b00);
    cyc("sh1b", 2'b10, 2'b11, '0, 2'b10, 1'b0, 2'b00);
    idle("c_sh", 1'b1, 2'b00);
    settle();
    chk("lit_0d", 32'(Q[15:8]), 32'h0D);

    // Tristate: out=1234, enables change mid-cycle.
    cyc("ld_1234", 2'b11, 2'b01, 16'h1234, '0, 1'b0, 2'b00);
    idle("c_1234", 1'b1, 2'b01);
    settle();
    chk("oe01_hi", 32'(Q[15:8]), 32'h12);
    N_OE = 2'b10;
    #1;
    chk("oe10_lo", 32'(Q[7:0]), 32'h34);
    N_OE = 2'b00;
    #1;
    chk("oe00", 32'(Q), 32'h1234);
    idle("oe_hold", 1'b0, 2'b00);

    // Reset between load and commit: staging discarded, carry cleared.
    cyc("ld_ff", 2'b01, 2'b01, 16'h00FF, '0, 1'b0, 2'b00);
    cyc("inc_wrap", 2'b01, 2'b10, '0, '0, 1'b0, 2'b00);
    cyc("ld_77", 2'b01, 2'b01, 16'h0077, '0, 1'b0, 2'b00);
    settle();
    chk("carry_held", 32'(CARRY), 32'h1);
    RST = 1'b1;
    #1;
    chk("arst_q", 32'(Q), 32'h0);
    chk("arst_carry", 32'(CARRY), 32'h0);
    RST = 1'b0;
    model_reset();
    idle("c_after_rst", 1'b1, 2'b00);
    settle();
    chk("lit_rst_pub", 32'(Q), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++)
      cyc("rnd", NCH'($urandom), 2'($urandom), BW'($urandom), NCH'($urandom),
          1'($urandom), NCH'($urandom));
    idle("rnd_end", 1'b1, 2'b00);

    begin
      int waited = 0;
      while (sb.size() != 0 && waited < 20) begin
        @(posedge CLK);
        waited++;
      end
      #3;
      chk("sb_drain", 32'(sb.size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
